// File: rtl/spi_boot_loader_if.sv
// SPI flash and RAM write-port bundle for spi_boot_loader; master = loader side,
// slave = flash/RAM side.
interface spi_boot_loader_if #(
  parameter int ADR_WIDTH = 13
);
  logic                 spi_sclk;
  logic [1:0]           spi_ss;
  logic                 spi_mosi;
  logic                 spi_miso;
  logic                 mem_we;
  logic [ADR_WIDTH-1:0] mem_adr;
  logic [31:0]          mem_dat;
  logic                 mem_ack;

  modport master (
    output spi_sclk, spi_ss, spi_mosi, mem_we, mem_adr, mem_dat,
    input  spi_miso, mem_ack
  );

  modport slave (
    input  spi_sclk, spi_ss, spi_mosi, mem_we, mem_adr, mem_dat,
    output spi_miso, mem_ack
  );
endinterface

// File: rtl/spi_boot_loader.sv
// Streams a length-prefixed image from SPI flash (read 0x03 @ 0) into RAM, then releases the CPU.
// Define BOOT_LOADER_WATCHDOG_EN to abort into ERR when a RAM write is not acked within 256 cycles.
module spi_boot_loader #(
  parameter int ADR_WIDTH = 13,
  parameter int CLK_DIV   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  spi_boot_loader_if.master bus,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, CMD, LEN, DATA, WRITE, DONE, ERR} state_t;

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [31:0] READ_CMD = 32'h0300_0000;
  localparam logic [63:0] MAX_LEN  = 64'd4 << ADR_WIDTH;

  state_t               state_q, state_d;
  logic [7:0]           div_q, div_d;
  logic                 sclk_q, sclk_d;
  logic [4:0]           bitCnt_q, bitCnt_d;
  logic [31:0]          cmd_q, cmd_d;
  logic [31:0]          shift_q, shift_d;
  logic [31:0]          byteCnt_q, byteCnt_d;
  logic [31:0]          len_q, len_d;
  logic                 evt_q, evt_d;
  logic [ADR_WIDTH-1:0] adr_q, adr_d;
  logic [31:0]          dat_q, dat_d;

  logic        shifting;
  logic        tick;
  logic        rise;
  logic        fall;
  logic [31:0] byteInc;
  logic        lenBad;
  logic [31:0] padded;

`ifdef BOOT_LOADER_WATCHDOG_EN
  logic [7:0] wdog_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
    end else if (state_q == WRITE) begin
      wdog_q <= wdog_q + 8'd1;
    end else begin
      wdog_q <= '0;
    end
  end
`endif

  assign shifting = (state_q == CMD) || (state_q == LEN) || (state_q == DATA);
  assign tick     = shifting && (div_q == DIV_LAST);
  assign rise     = tick && !sclk_q;
  assign fall     = tick && sclk_q;
  assign byteInc  = byteCnt_q + 32'd1;
  assign lenBad   = (shift_q < 32'd4) || ({32'h0, shift_q} > MAX_LEN);

  // Unreceived low-order bytes of a final partial word read as zero.
  always_comb begin
    case (byteCnt_q[1:0])
      2'd1:    padded = {shift_q[7:0], 24'h0};
      2'd2:    padded = {shift_q[15:0], 16'h0};
      2'd3:    padded = {shift_q[23:0], 8'h0};
      default: padded = shift_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      sclk_q    <= 1'b0;
      bitCnt_q  <= '0;
      cmd_q     <= '0;
      shift_q   <= '0;
      byteCnt_q <= '0;
      len_q     <= '0;
      evt_q     <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      sclk_q    <= sclk_d;
      bitCnt_q  <= bitCnt_d;
      cmd_q     <= cmd_d;
      shift_q   <= shift_d;
      byteCnt_q <= byteCnt_d;
      len_q     <= len_d;
      evt_q     <= evt_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
    end
  end

  // A completed command/word is flagged on the rising edge but acted on at the
  // following falling edge, so every sclk high phase keeps its full length.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    sclk_d    = sclk_q;
    bitCnt_d  = bitCnt_q;
    cmd_d     = cmd_q;
    shift_d   = shift_q;
    byteCnt_d = byteCnt_q;
    len_d     = len_q;
    evt_d     = evt_q;
    adr_d     = adr_q;
    dat_d     = dat_q;

    case (state_q)
      IDLE: begin
        state_d   = CMD;
        cmd_d     = READ_CMD;
        div_d     = '0;
        sclk_d    = 1'b0;
        bitCnt_d  = '0;
        byteCnt_d = '0;
        evt_d     = 1'b0;
      end

      CMD, LEN, DATA: begin
        if (tick) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
        end else begin
          div_d = div_q + 8'd1;
        end

        if (rise) begin
          bitCnt_d = bitCnt_q + 5'd1;
          if (state_q == CMD) begin
            evt_d = (bitCnt_q == 5'd31);
          end else begin
            shift_d = {shift_q[30:0], bus.spi_miso};
            if (bitCnt_q[2:0] == 3'd7) begin
              byteCnt_d = byteInc;
              evt_d     = (byteInc[1:0] == 2'b00) ||
                          ((state_q == DATA) && (byteInc == len_q));
            end
          end
        end

        if (fall) begin
          if (state_q == CMD) begin
            cmd_d = {cmd_q[30:0], 1'b0};
          end
          if (evt_q) begin
            evt_d = 1'b0;
            if (state_q == CMD) begin
              state_d = LEN;
            end else if ((state_q == LEN) && lenBad) begin
              state_d = ERR;
            end else begin
              if (state_q == LEN) begin
                len_d = shift_q;
              end
              dat_d   = padded;
              state_d = WRITE;
            end
          end
        end
      end

      WRITE: begin
        if (bus.mem_ack) begin
          if (byteCnt_q == len_q) begin
            state_d = DONE;
          end else begin
            state_d = DATA;
            adr_d   = adr_q + ADR_WIDTH'(1);
          end
        end
`ifdef BOOT_LOADER_WATCHDOG_EN
        else if (wdog_q == 8'hFF) begin
          state_d = ERR;
        end
`endif
      end

      DONE, ERR: begin
        sclk_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.spi_sclk = sclk_q;
  assign bus.spi_ss   = {1'b1, ~(shifting || (state_q == WRITE))};
  assign bus.spi_mosi = cmd_q[31];
  assign bus.mem_we   = (state_q == WRITE);
  assign bus.mem_adr  = adr_q;
  assign bus.mem_dat  = dat_q;
  assign done         = (state_q == DONE);
  assign err          = (state_q == ERR);
  assign cpu_rst      = (state_q != DONE);

endmodule

// File: tb/tb_spi_boot_loader.sv
// Self-checking bench for spi_boot_loader: a flash model serves an image, an image-level
// model predicts the RAM writes, and a per-cycle monitor checks bus timing and write contents.
module tb_spi_boot_loader;
  localparam int          CLK_DIV   = 2;
  localparam int          ADR_WIDTH = 13;
  localparam logic [63:0] MAX_LEN   = 64'd4 << ADR_WIDTH;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  logic clk;
  logic reset_n;
  logic cpu_rst;
  logic done;
  logic err;

  spi_boot_loader_if #(.ADR_WIDTH(ADR_WIDTH)) bus();

  spi_boot_loader #(.ADR_WIDTH(ADR_WIDTH), .CLK_DIV(CLK_DIV)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .cpu_rst(cpu_rst),
    .done   (done),
    .err    (err)
  );

  int          total = 0;
  int          bad = 0;
  logic [7:0]  img [0:255];
  int          ackDelay = 0;
  bit          ackLow = 0;
  bit          monEn = 0;
  wr_t         expQ[$];
  logic [31:0] logAdr[$];
  logic [31:0] logDat[$];
  int          weRises = 0;
  int          weCnt = 0;
  int          riseCnt = 0;
  logic [31:0] cmdCap = '0;
  logic [31:0] cmdSeen = '0;
  int          cmdCnt = 0;
  logic        misoBit = 1'b0;
  logic        ss0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign ss0          = bus.spi_ss[0];
  assign bus.spi_miso = misoBit;
  assign bus.mem_ack  = !ackLow && (weCnt >= ackDelay);

  always @(posedge clk) weCnt <= bus.mem_we ? weCnt + 1 : 0;

  function automatic logic flashBit(input int n);
    logic [7:0] b;
    b = ((n / 8) < 256) ? img[n / 8] : 8'h00;
    return b[7 - (n % 8)];
  endfunction

  // Flash: capture the command on rising sclk, present data MSB-first on falling sclk.
  always @(posedge bus.spi_sclk or posedge ss0) begin
    if (ss0) begin
      riseCnt <= 0;
      cmdCap  <= '0;
    end else begin
      if (riseCnt < 32) cmdCap <= {cmdCap[30:0], bus.spi_mosi};
      if (riseCnt == 31) begin
        cmdSeen <= {cmdCap[30:0], bus.spi_mosi};
        cmdCnt  <= cmdCnt + 1;
      end
      riseCnt <= riseCnt + 1;
    end
  end

  always @(negedge bus.spi_sclk) begin
    if (riseCnt >= 32) misoBit <= flashBit(riseCnt - 32);
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle monitor.
  int          hiCnt = 0;
  int          lowCnt = 0;
  int          weLen = 0;
  logic        prevWe = 0;
  logic        prevSclk = 0;
  logic        prevMosi = 0;
  logic [31:0] prevAdr = '0;
  logic [31:0] prevDat = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n || !monEn) begin
        hiCnt = 0; lowCnt = 0; weLen = 0;
        prevWe = 0; prevSclk = 0; prevMosi = 0;
      end else begin
        checkOutput("ss1_high", 32'(bus.spi_ss[1]), 32'd1);
        checkOutput("cpu_rst_vs_done", 32'(cpu_rst), 32'(!done));
        if (!ss0) checkOutput("busy_flags", {30'd0, done, err}, 32'd0);
        if (done || err) checkOutput("idle_ss", 32'(bus.spi_ss), 32'd3);
        checkOutput("mosi_change_sclk_low", 32'((bus.spi_mosi !== prevMosi) && bus.spi_sclk), 32'd0);
        if (bus.mem_we) begin
          checkOutput("write_sclk_low", 32'(bus.spi_sclk), 32'd0);
          if (!prevWe) begin
            weRises++;
            if (expQ.size() == 0) begin
              checkOutput("write_unexpected", 32'd1, 32'd0);
            end else begin
              checkOutput("write_adr", 32'(bus.mem_adr), expQ[0].adr);
              checkOutput("write_dat", bus.mem_dat, expQ[0].dat);
            end
          end else begin
            checkOutput("adr_stable", 32'(bus.mem_adr), prevAdr);
            checkOutput("dat_stable", bus.mem_dat, prevDat);
          end
          weLen++;
          if (bus.mem_ack) begin
            logAdr.push_back(32'(bus.mem_adr));
            logDat.push_back(bus.mem_dat);
            if (expQ.size() > 0) void'(expQ.pop_front());
          end
        end else if (prevWe) begin
          if (!ackLow) checkOutput("we_length", 32'(weLen), 32'(ackDelay + 1));
          weLen = 0;
        end
        if (bus.spi_sclk && !prevSclk) begin
          checkOutput("sclk_low_phase", 32'(lowCnt), 32'(CLK_DIV));
          lowCnt = 0;
          hiCnt = 1;
        end else if (bus.spi_sclk) begin
          hiCnt++;
        end else begin
          if (prevSclk) begin
            checkOutput("sclk_high_phase", 32'(hiCnt), 32'(CLK_DIV));
            hiCnt = 0;
          end
          if (!ss0 && !bus.mem_we) lowCnt++;
        end
        prevWe   = bus.mem_we;
        prevSclk = bus.spi_sclk;
        prevMosi = bus.spi_mosi;
        prevAdr  = 32'(bus.mem_adr);
        prevDat  = bus.mem_dat;
      end
    end
  end

  // Image-level model: word 0 is the length, later words big-endian, tail zero-padded.
  task automatic buildModel(output int nWords, output bit isErr);
    logic [31:0] len;
    logic [31:0] word;
    logic [7:0]  b;
    len = {img[0], img[1], img[2], img[3]};
    expQ.delete();
    logAdr.delete();
    logDat.delete();
    weRises = 0;
    isErr = (len < 32'd4) || ({32'h0, len} > MAX_LEN);
    nWords = 0;
    if (!isErr) begin
      nWords = int'((len + 32'd3) / 32'd4);
      for (int w = 0; w < nWords; w++) begin
        word = '0;
        for (int k = 0; k < 4; k++) begin
          b = (32'(4 * w + k) < len) ? img[4 * w + k] : 8'h00;
          word = (word << 8) | 32'(b);
        end
        expQ.push_back('{adr: 32'(w), dat: word});
      end
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_sclk"}, 32'(bus.spi_sclk), 32'd0);
    checkOutput({tag, "_ss"}, 32'(bus.spi_ss), 32'd3);
    checkOutput({tag, "_mosi"}, 32'(bus.spi_mosi), 32'd0);
    checkOutput({tag, "_we"}, 32'(bus.mem_we), 32'd0);
    checkOutput({tag, "_adr"}, 32'(bus.mem_adr), 32'd0);
    checkOutput({tag, "_dat"}, bus.mem_dat, 32'd0);
    checkOutput({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    reset_n = 1'b1;
    monEn = 1'b1;
    checkOutput("idle_ss", 32'(bus.spi_ss), 32'd3);
    @(negedge clk);
    checkOutput("cmd_ss_low", 32'(bus.spi_ss), 32'd2);
  endtask

  task automatic holdReset();
    monEn = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
  endtask

  task automatic asyncResetPulse(input string tag);
    monEn = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkResetValues(tag);
  endtask

  task automatic waitFinish(input bit expErr, input int nWords, input int cmdBefore);
    int cyc;
    cyc = 0;
    while (!(done || err) && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("finish_timeout", 32'(done || err), 32'd1);
    repeat (6) @(negedge clk);
    checkOutput("end_done", 32'(done), 32'(!expErr));
    checkOutput("end_err", 32'(err), 32'(expErr));
    checkOutput("end_cpu_rst", 32'(cpu_rst), 32'(expErr));
    checkOutput("end_ss", 32'(bus.spi_ss), 32'd3);
    checkOutput("end_sclk", 32'(bus.spi_sclk), 32'd0);
    checkOutput("end_we", 32'(bus.mem_we), 32'd0);
    checkOutput("writes_pending", 32'(expQ.size()), 32'd0);
    checkOutput("write_count", 32'(logAdr.size()), 32'(nWords));
    checkOutput("cmd_count", 32'(cmdCnt - cmdBefore), 32'd1);
    checkOutput("cmd_word", cmdSeen, 32'h0300_0000);
  endtask

  task automatic applyStimulus(input int delay);
    int nWords;
    bit isErr;
    int cmdBefore;
    ackDelay = delay;
    ackLow = 0;
    holdReset();
    buildModel(nWords, isErr);
    cmdBefore = cmdCnt;
    releaseReset();
    waitFinish(isErr, nWords, cmdBefore);
  endtask

  task automatic loadImage(input logic [31:0] len, input int nData, input logic [7:0] seed);
    img[0] = len[31:24];
    img[1] = len[23:16];
    img[2] = len[15:8];
    img[3] = len[7:0];
    for (int i = 4; i < 256; i++) img[i] = (i - 4 < nData) ? 8'(seed + 8'(17 * i)) : 8'h00;
  endtask

  task automatic stuckAckTest();
    int nWords;
    bit isErr;
    int cyc;
    loadImage(32'd8, 4, 8'h5A);
    ackDelay = 0;
    ackLow = 1;
    holdReset();
    buildModel(nWords, isErr);
    releaseReset();
    cyc = 0;
    while (!bus.mem_we && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("stuck_we_seen", 32'(bus.mem_we), 32'd1);
`ifdef BOOT_LOADER_WATCHDOG_EN
    cyc = 0;
    while (!err && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("wdog_cycles", 32'(cyc), 32'd256);
    checkOutput("wdog_cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("wdog_we", 32'(bus.mem_we), 32'd0);
    checkOutput("wdog_ss", 32'(bus.spi_ss), 32'd3);
`else
    repeat (400) @(negedge clk);
    checkOutput("stuck_we_held", 32'(bus.mem_we), 32'd1);
    checkOutput("stuck_no_err", 32'(err), 32'd0);
    checkOutput("stuck_sclk", 32'(bus.spi_sclk), 32'd0);
`endif
    asyncResetPulse("midwrite_reset");
    ackLow = 0;
    buildModel(nWords, isErr);
    cyc = cmdCnt;
    releaseReset();
    waitFinish(isErr, nWords, cyc);
  endtask

  task automatic midDataResetTest();
    int nWords;
    bit isErr;
    int cyc;
    img[0] = 8'h00; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h0A;
    img[4] = 8'h11; img[5] = 8'h22; img[6] = 8'h33; img[7] = 8'h44;
    img[8] = 8'h55; img[9] = 8'h66;
    ackDelay = 1;
    ackLow = 0;
    holdReset();
    buildModel(nWords, isErr);
    releaseReset();
    cyc = 0;
    while (logAdr.size() < 1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("middata_first_write", 32'(logAdr.size()), 32'd1);
    repeat (12) @(negedge clk);
    asyncResetPulse("middata_reset");
    buildModel(nWords, isErr);
    cyc = cmdCnt;
    repeat (2) @(negedge clk);
    releaseReset();
    waitFinish(isErr, nWords, cyc);
    if (logDat.size() == 3) checkOutput("middata_tail", logDat[2], 32'h5566_0000);
    else checkOutput("middata_count", 32'(logDat.size()), 32'd3);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 256; i++) img[i] = 8'h00;

    img[0] = 8'h00; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h08;
    img[4] = 8'hDE; img[5] = 8'hAD; img[6] = 8'hBE; img[7] = 8'hEF;
    applyStimulus(0);
    if (logDat.size() == 2) begin
      checkOutput("basic_w0_adr", logAdr[0], 32'd0);
      checkOutput("basic_w0_dat", logDat[0], 32'h0000_0008);
      checkOutput("basic_w1_adr", logAdr[1], 32'd1);
      checkOutput("basic_w1_dat", logDat[1], 32'hDEAD_BEEF);
    end else begin
      checkOutput("basic_count", 32'(logDat.size()), 32'd2);
    end

    for (int d = 0; d < 2; d++) begin
      img[0] = 8'h00; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h0A;
      img[4] = 8'h11; img[5] = 8'h22; img[6] = 8'h33; img[7] = 8'h44;
      img[8] = 8'h55; img[9] = 8'h66; img[10] = 8'h77; img[11] = 8'h88;
      applyStimulus(d * 5);
      if (logDat.size() == 3) begin
        checkOutput("partial_w1", logDat[1], 32'h1122_3344);
        checkOutput("partial_w2_adr", logAdr[2], 32'd2);
        checkOutput("partial_w2", logDat[2], 32'h5566_0000);
      end else begin
        checkOutput("partial_count", 32'(logDat.size()), 32'd3);
      end
    end

    loadImage(32'd2, 8, 8'h10);
    applyStimulus(0);
    checkOutput("short_no_write", 32'(weRises), 32'd0);

    loadImage(32'h0000_8001, 8, 8'h20);
    applyStimulus(0);
    checkOutput("long_no_write", 32'(weRises), 32'd0);

    loadImage(32'd4, 8, 8'h30);
    applyStimulus(2);
    checkOutput("header_only_writes", 32'(weRises), 32'd1);

    for (int t = 0; t < 6; t++) begin
      logic [31:0] len;
      len = 32'($urandom_range(5, 40));
      img[0] = len[31:24]; img[1] = len[23:16]; img[2] = len[15:8]; img[3] = len[7:0];
      for (int i = 4; i < 48; i++) img[i] = 8'($urandom);
      applyStimulus(int'($urandom_range(0, 3)));
    end

    stuckAckTest();
    midDataResetTest();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_boot_loader.md
SPI_BOOT_LOADER -- requirements
Module: spi_boot_loader

Interface
REQ-001 Parameter ADR_WIDTH, default 13, word-address width of the on-chip RAM write port.
REQ-002 Parameter CLK_DIV, default 2, clk cycles per spi_sclk half-period (legal range 1-255).
REQ-003 Decided: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock; all state changes occur on its rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 spi_sclk  out  1  SPI clock, mode 0, idles low.
REQ-007 spi_ss  out  2  active-low slave selects; bit0 is the flash; bit1 is held high.
REQ-008 spi_mosi  out  1  serial command data, MSB first.
REQ-009 spi_miso  in  1  serial flash data, MSB first.
REQ-010 mem_we  out  1  RAM write request.
REQ-011 mem_adr  out  ADR_WIDTH  RAM word address.
REQ-012 mem_dat  out  32  RAM write data, big-endian (first received byte in [31:24]).
REQ-013 mem_ack  in  1  RAM write acknowledge.
REQ-014 cpu_rst  out  1  active-high CPU reset, released only on success.
REQ-015 done  out  1  image loaded.
REQ-016 err  out  1  load aborted.

Function
REQ-017 FSM states: IDLE, CMD, LEN, DATA, WRITE, DONE, ERR.
REQ-018 IDLE lasts exactly one cycle after reset release, then enters CMD and drives spi_ss[0] low.
REQ-019 CMD shifts out 32 bits: 0x03 read opcode, then address 0x000000; miso bits during CMD are discarded.
REQ-020 spi_mosi changes only while spi_sclk is low; spi_miso is sampled in the clk cycle in which spi_sclk rises.
REQ-021 Each sclk phase lasts exactly CLK_DIV clk cycles; 8 sclk rising edges constitute one byte.
REQ-022 LEN receives 4 bytes; their big-endian concatenation is the image length L in bytes, header included.
REQ-023 The length word is itself image word 0 and is written to mem_adr 0 via WRITE.
REQ-024 L < 4 or L > 4*2^ADR_WIDTH: enter ERR after the header word is received, with no write issued.
REQ-025 DATA assembles bytes into a word; after every 4th byte, or when the byte count reaches L, enter WRITE.
REQ-026 A final partial word is zero-padded in its unreceived low-order bytes.
REQ-027 WRITE holds mem_we=1 with stable mem_adr/mem_dat until the cycle mem_ack=1; mem_we drops the next cycle.
REQ-028 While in WRITE, spi_sclk stays low and no bit is shifted; shifting resumes one cycle after ack.
REQ-029 mem_adr increments by 1 after each acknowledged write; the address counter width is ADR_WIDTH and never wraps within a legal L.
REQ-030 After the write that completes L bytes: spi_ss=2'b11, spi_sclk=0, enter DONE, done=1, cpu_rst=0 (same cycle).
REQ-031 ERR: spi_ss=2'b11, spi_sclk=0, mem_we=0, err=1, cpu_rst=1; DONE and ERR are exited only by reset.

Reset
REQ-032 Reset values: spi_sclk=0, spi_ss=2'b11, spi_mosi=0, mem_we=0, mem_adr=0, mem_dat=0, cpu_rst=1, done=0, err=0, state=IDLE.
REQ-033 Reset asserted mid-transfer (including mid-WRITE) takes effect immediately; the load restarts from CMD after release.

Configuration
REQ-034 Macro BOOT_LOADER_WATCHDOG_EN: when defined, a 256-cycle counter runs in WRITE; if mem_ack is not seen within 256 cycles of mem_we rising, enter ERR.
REQ-035 Without BOOT_LOADER_WATCHDOG_EN, WRITE waits for mem_ack indefinitely and no counter is synthesized.

Verification
REQ-036 CLK_DIV=2, flash image 00000008 DEADBEEF, mem_ack tied high -> writes (0,00000008), (1,DEADBEEF); done=1; cpu_rst=0; spi_ss=11.
REQ-037 Image L=0000000A with bytes 11 22 33 44 55 66 after the header -> writes (1,11223344), (2,55660000); done=1.
REQ-038 Header 00000002 -> no mem_we pulse; err=1; cpu_rst=1; spi_ss=11.
REQ-039 mem_ack delayed 5 cycles on every write -> mem_we held 6 cycles; no sclk edge during WRITE; data is correct.
REQ-040 With BOOT_LOADER_WATCHDOG_EN, mem_ack tied low -> err=1 exactly 256 cycles after the first mem_we rise.
REQ-041 reset_n pulsed low during DATA -> all outputs at reset values asynchronously; after release CMD reissues 0x03000000 and the load completes.
